// File: rtl/decode_issue_buffer.sv
// In-order N-lane instruction buffer between the instruction queue and the operand stage.
// Accepts a prefix-valid group per cycle and presents the oldest LANES entries for partial in-order issue.
module decode_issue_buffer #(
  parameter int                LANES       = 2,
  parameter int                SLOTS       = 4,
  parameter int                PC_W        = 64,
  parameter int                INST_W      = 32,
  parameter logic [INST_W-1:0] ENDSIM_INST = INST_W'(32'h0000_006b)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES-1:0]              in_valid_i,
  input  logic [LANES*PC_W-1:0]         in_pc_i,
  input  logic [LANES*INST_W-1:0]       in_inst_i,
  output logic                          in_ready_o,
  output logic [LANES-1:0]              out_valid_o,
  output logic [LANES*PC_W-1:0]         out_pc_o,
  output logic [LANES*INST_W-1:0]       out_inst_o,
  output logic [LANES-1:0]              out_endsim_o,
  input  logic [$clog2(LANES+1)-1:0]    out_accept_i,
  input  logic                          flush_i,
  output logic [$clog2(SLOTS+1)-1:0]    count_o
);

  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int ACC_W = $clog2(LANES + 1);

  logic [PC_W-1:0]   pc_mem   [SLOTS];
  logic [INST_W-1:0] inst_mem [SLOTS];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [ACC_W-1:0] n_in, n_in_eff, n_out;
  logic             run;
  logic             ready;
  logic [PTR_W-1:0] wr_idx [LANES];
  logic [PTR_W-1:0] rd_idx [LANES];

  // Registered occupancy only, so a same-cycle dequeue never opens the input.
  assign ready      = (int'(cnt_reg) + LANES) <= SLOTS;
  assign in_ready_o = ready;
  assign count_o    = cnt_reg;

  // Only the leading run of valid lanes counts; anything after the first gap is ignored.
  always_comb begin
    n_in = '0;
    run  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      run = run & in_valid_i[i];
      if (run) n_in = n_in + ACC_W'(1);
    end
  end

  always_comb begin
    n_out     = (int'(out_accept_i) > int'(cnt_reg)) ? ACC_W'(cnt_reg) : out_accept_i;
    n_in_eff  = ready ? n_in : '0;
    head_next = PTR_W'((int'(head_reg) + int'(n_out)) % SLOTS);
    tail_next = PTR_W'((int'(tail_reg) + int'(n_in_eff)) % SLOTS);
    cnt_next  = CNT_W'(int'(cnt_reg) + int'(n_in_eff) - int'(n_out));
    if (flush_i) begin
      head_next = '0;
      tail_next = '0;
      cnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
      cnt_reg  <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        pc_mem[s]   <= '0;
        inst_mem[s] <= '0;
      end
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      cnt_reg  <= cnt_next;
      if (!flush_i) begin
        for (int i = 0; i < LANES; i++) begin
          if (i < int'(n_in_eff)) begin
            pc_mem[wr_idx[i]]   <= in_pc_i[i*PC_W +: PC_W];
            inst_mem[wr_idx[i]] <= in_inst_i[i*INST_W +: INST_W];
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign wr_idx[gi]       = PTR_W'((int'(tail_reg) + gi) % SLOTS);
      assign rd_idx[gi]       = PTR_W'((int'(head_reg) + gi) % SLOTS);
      assign out_valid_o[gi]  = gi < int'(cnt_reg);
      assign out_pc_o[gi*PC_W +: PC_W]       = out_valid_o[gi] ? pc_mem[rd_idx[gi]] : '0;
      assign out_inst_o[gi*INST_W +: INST_W] = out_valid_o[gi] ? inst_mem[rd_idx[gi]] : '0;
      assign out_endsim_o[gi] = out_valid_o[gi] && (inst_mem[rd_idx[gi]] == ENDSIM_INST);
    end
  endgenerate

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Scoreboard bench for decode_issue_buffer: a queue of buffered entries predicts every presented lane.
module tb_decode_issue_buffer;
  localparam int LANES  = 2;
  localparam int SLOTS  = 4;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int ACC_W  = $clog2(LANES + 1);
  localparam int CNT_W  = $clog2(SLOTS + 1);
  localparam logic [INST_W-1:0] ENDSIM = 32'h0000_006b;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LANES-1:0]        in_valid_i;
  logic [LANES*PC_W-1:0]   in_pc_i;
  logic [LANES*INST_W-1:0] in_inst_i;
  logic                    in_ready_o;
  logic [LANES-1:0]        out_valid_o;
  logic [LANES*PC_W-1:0]   out_pc_o;
  logic [LANES*INST_W-1:0] out_inst_o;
  logic [LANES-1:0]        out_endsim_o;
  logic [ACC_W-1:0]        out_accept_i;
  logic                    flush_i;
  logic [CNT_W-1:0]        count_o;

  entry_t sb[$];
  int checks = 0;
  int errors = 0;
  int illegal_hits = 0;

  always #5 clk = ~clk;

  decode_issue_buffer #(
    .LANES(LANES), .SLOTS(SLOTS), .PC_W(PC_W), .INST_W(INST_W), .ENDSIM_INST(ENDSIM)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_pc_i(in_pc_i), .in_inst_i(in_inst_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_endsim_o(out_endsim_o), .out_accept_i(out_accept_i), .flush_i(flush_i),
    .count_o(count_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic entry_t mk(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst);
    entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

  task automatic check_outputs();
    logic [LANES-1:0]        ev;
    logic [LANES*PC_W-1:0]   ep;
    logic [LANES*INST_W-1:0] ei;
    logic [LANES-1:0]        ee;
    ev = '0; ep = '0; ei = '0; ee = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < sb.size()) begin
        ev[i] = 1'b1;
        ep[i*PC_W +: PC_W]     = sb[i].pc;
        ei[i*INST_W +: INST_W] = sb[i].inst;
        ee[i] = (sb[i].inst == ENDSIM);
      end
    end
    chk("sb_valid", out_valid_o, ev);
    chk("sb_pc", out_pc_o, ep);
    chk("sb_inst", out_inst_o, ei);
    chk("sb_endsim", out_endsim_o, ee);
    chk("sb_count", count_o, sb.size());
    chk("sb_ready", in_ready_o, (SLOTS - sb.size()) >= LANES);
  endtask

  // One transaction: check registered outputs, drive a group, clock, then advance the scoreboard.
  task automatic cycle(input logic [LANES-1:0] v, input entry_t e0, input entry_t e1,
                       input int acc, input logic fl, input logic rs);
    entry_t grp[LANES];
    int     n_in;
    int     n_out;
    bit     rdy;
    @(negedge clk);
    check_outputs();
    if ((v & (v + 1'b1)) != '0) illegal_hits++;
    if (acc > sb.size()) illegal_hits++;
    grp[0] = e0;
    grp[1] = e1;
    in_valid_i   = v;
    in_pc_i      = {e1.pc, e0.pc};
    in_inst_i    = {e1.inst, e0.inst};
    out_accept_i = ACC_W'(acc);
    flush_i      = fl;
    rst          = rs;
    rdy  = (SLOTS - sb.size()) >= LANES;
    n_in = 0;
    for (int i = 0; i < LANES; i++)
      if (v[i] && n_in == i) n_in++;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      sb.delete();
    end else begin
      n_out = (acc < sb.size()) ? acc : sb.size();
      repeat (n_out) void'(sb.pop_front());
      if (rdy)
        for (int i = 0; i < n_in; i++) sb.push_back(grp[i]);
    end
    $display("txn v=%b acc=%0d flush=%b rst=%b rdy=%b -> model_cnt=%0d dut_cnt=%0d",
             v, acc, fl, rs, rdy, sb.size(), count_o);
  endtask

  initial begin
    entry_t z, a, b, c, d, e, f, g, h, i1, j, k, l, m, n;
    z  = '0;
    a  = mk(64'h1000, 32'h0000_0013);
    b  = mk(64'h1004, 32'h0050_0093);
    c  = mk(64'h2000, 32'h0000_0113);
    d  = mk(64'h2004, 32'h0000_0193);
    e  = mk(64'h2008, 32'h0000_0213);
    f  = mk(64'h200c, 32'h0000_0293);
    g  = mk(64'h2010, 32'h0000_0313);
    h  = mk(64'h2014, 32'h0000_0393);
    i1 = mk(64'h3000, 32'h0000_0413);
    j  = mk(64'h3004, 32'h0000_0493);
    k  = mk(64'h4000, 32'h0000_0013);
    l  = mk(64'h4004, ENDSIM);
    m  = mk(64'h5000, 32'h0000_0513);
    n  = mk(64'h5004, 32'h0000_0593);

    rst = 1'b1; flush_i = 1'b0; in_valid_i = '0; in_pc_i = '0; in_inst_i = '0; out_accept_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_pc", out_pc_o, 0);
    chk("rst_ready", in_ready_o, 1);

    // basic flow
    cycle(2'b11, a, b, 0, 1'b0, 1'b0);
    chk("basic_valid", out_valid_o, 2'b11);
    chk("basic_pc", out_pc_o, {64'h1004, 64'h1000});
    chk("basic_count", count_o, 2);
    chk("basic_ready", in_ready_o, 1);

    // partial issue
    cycle(2'b00, z, z, 1, 1'b0, 1'b0);
    chk("partial_valid", out_valid_o, 2'b01);
    chk("partial_pc0", out_pc_o[PC_W-1:0], 64'h1004);
    chk("partial_count", count_o, 1);

    // full, back-pressure, wrap
    cycle(2'b00, z, z, 0, 1'b0, 1'b1);
    cycle(2'b11, c, d, 0, 1'b0, 1'b0);
    cycle(2'b11, e, f, 0, 1'b0, 1'b0);
    chk("full_ready", in_ready_o, 0);
    chk("full_valid", out_valid_o, 2'b11);
    cycle(2'b11, g, h, 0, 1'b0, 1'b0);
    chk("blocked_count", count_o, 4);
    chk("blocked_pc0", out_pc_o[PC_W-1:0], 64'h2000);
    cycle(2'b11, g, h, 2, 1'b0, 1'b0);
    chk("accept_count", count_o, 2);
    chk("accept_ready", in_ready_o, 1);
    cycle(2'b11, g, h, 0, 1'b0, 1'b0);
    chk("wrap_count", count_o, 4);
    chk("wrap_pc", out_pc_o, {64'h200c, 64'h2008});
    cycle(2'b00, z, z, 2, 1'b0, 1'b0);
    chk("wrap_new_pc", out_pc_o, {64'h2014, 64'h2010});

    // simultaneous enqueue/dequeue, then flush
    cycle(2'b01, i1, z, 0, 1'b0, 1'b0);
    chk("three_count", count_o, 3);
    cycle(2'b01, j, z, 2, 1'b0, 1'b0);
    chk("simul_not_ready_count", count_o, 1);
    chk("simul_pc0", out_pc_o[PC_W-1:0], 64'h3000);
    cycle(2'b11, c, d, 1, 1'b0, 1'b0);
    chk("simul_count", count_o, 2);
    cycle(2'b11, m, n, 1, 1'b1, 1'b0);
    chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);

    // end-of-simulation flag follows the entry as it shifts down
    cycle(2'b11, k, l, 0, 1'b0, 1'b0);
    chk("endsim_lane1", out_endsim_o, 2'b10);
    cycle(2'b00, z, z, 1, 1'b0, 1'b0);
    chk("endsim_lane0", out_endsim_o, 2'b01);
    cycle(2'b00, z, z, 1, 1'b0, 1'b0);

    // reset wins over flush with a full buffer
    cycle(2'b11, a, b, 0, 1'b0, 1'b0);
    cycle(2'b11, c, d, 0, 1'b0, 1'b0);
    chk("prereset_count", count_o, 4);
    cycle(2'b11, e, f, 2, 1'b1, 1'b1);
    chk("midrst_count", count_o, 0);
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_pc", out_pc_o, 0);
    chk("midrst_inst", out_inst_o, 0);
    chk("midrst_endsim", out_endsim_o, 0);
    chk("midrst_ready", in_ready_o, 1);

    // non-prefix valid pattern enqueues nothing
    cycle(2'b10, m, n, 0, 1'b0, 1'b0);
    chk("nonprefix_count", count_o, 0);
    chk("nonprefix_flagged", illegal_hits, 1);
    cycle(2'b00, z, z, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
